// File: rtl/somador_serial.sv
// -----------------------------------------------------------------------------
// somador_serial
//
// Bit-serial adder/subtractor. The operands are captured when start is seen in
// IDLE. One bit per clock is then processed, LSB first, through a single full
// adder for WIDTH cycles. The finished result is published in FIN, together
// with a one-cycle done pulse.
//
// Parameters
//   WIDTH     operand/result width in bits (1..32)
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     synchronous active-low reset
//   start     begin an operation (only honoured in IDLE)
//   sub       0 = a + b + cin, 1 = a - b (sampled with start)
//   cin       carry-in for add, ignored when sub = 1 (sampled with start)
//   a, b      operands (sampled with start)
//   soma      result register, held from one FIN to the next
//   cout      carry out of the MSB (for subtract: 1 = no borrow)
//   overflow  two's-complement signed overflow
//   busy      high in SHIFT and FIN
//   done      one-cycle pulse while FIN, marks soma/cout/overflow valid
// -----------------------------------------------------------------------------
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] soma,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] soma_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             overflow_reg;

    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;

    // Single full adder working on the current LSBs of the operand shifters.
    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) |
                        (a_reg[0] & carry_reg) |
                        (b_reg[0] & carry_reg);
    assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

    // Result shifter: new sum bit enters at the MSB, so after WIDTH shifts the
    // first (LSB) sum bit has reached bit 0. With WIDTH = 1 the loop is empty
    // and the shifter degenerates to a single bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
            assign sum_next[gi] = sum_reg[gi + 1];
        end
    endgenerate
    assign sum_next[WIDTH-1] = sum_bit;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            soma_reg     <= '0;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b here and seed the
                        // carry with 1, so SHIFT never needs to know about sub.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                    end
                end
                SHIFT: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= carry_next;
                    sum_reg   <= sum_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        // On the MSB step carry_reg is the carry into the MSB
                        // and carry_next the carry out of it.
                        soma_reg     <= sum_next;
                        cout_reg     <= carry_next;
                        overflow_reg <= carry_reg ^ carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign soma     = soma_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_somador_serial.sv
// -----------------------------------------------------------------------------
// tb_somador_serial
//
// Directed bench for somador_serial. A WIDTH=8 instance covers the arithmetic
// cases, busy/start-ignore rules, reset mid-operation and a back-to-back
// randomized sweep. A WIDTH=1 instance is swept over every input combination.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_somador_serial;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] soma;
    logic       cout;
    logic       overflow;
    logic       busy;
    logic       done;

    logic       start1;
    logic       sub1;
    logic       cin1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] soma1;
    logic       cout1;
    logic       overflow1;
    logic       busy1;
    logic       done1;

    int n_cmp = 0;
    int n_err = 0;

    somador_serial #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .soma     (soma),
        .cout     (cout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    somador_serial #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .sub      (sub1),
        .cin      (cin1),
        .a        (a1),
        .b        (b1),
        .soma     (soma1),
        .cout     (cout1),
        .overflow (overflow1),
        .busy     (busy1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a + b + cin, or a + ~b + 1 for subtract, on w bits.
    // Returns {overflow, cout, result[31:0]}.
    function automatic logic [33:0] model(input int w, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic ms,
                                          input logic mc);
        logic [32:0] mask;
        logic [32:0] full;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [31:0] res;
        logic        co;
        logic        ov;
        mask = (33'd1 << w) - 33'd1;
        aa   = ma & mask[31:0];
        bb   = ms ? (~mb & mask[31:0]) : (mb & mask[31:0]);
        full = {1'b0, aa} + {1'b0, bb} + {32'd0, (ms ? 1'b1 : mc)};
        res  = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
        return {ov, co, res};
    endfunction

    // One WIDTH=8 operation with hand-computed expectations.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic tc, input logic [7:0] es,
                       input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        $display("op %s: a=%02h b=%02h sub=%0d cin=%0d -> soma=%02h cout=%0d ovf=%0d lat=%0d",
                 tag, ta, tb, ts, tc, soma, cout, overflow, lat);
        chk({tag, ".lat"},  32'(lat),      32'd9);
        chk({tag, ".soma"}, 32'(soma),     32'(es));
        chk({tag, ".cout"}, 32'(cout),     32'(ec));
        chk({tag, ".ovf"},  32'(overflow), 32'(eo));
    endtask

    initial begin
        int nb;
        int nd;
        int gap;
        int lat;
        logic [33:0] exp;

        rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.soma",  32'(soma),     32'd0);
        chk("rst.cout",  32'(cout),     32'd0);
        chk("rst.ovf",   32'(overflow), 32'd0);
        chk("rst.busy",  32'(busy),     32'd0);
        chk("rst.done",  32'(done),     32'd0);
        chk("rst1.busy", 32'(busy1),    32'd0);
        rst_n = 1'b1;

        // Directed arithmetic
        op8("add_nc",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_cin",  8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        op8("sub_cin",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        op8("sub_neg",  8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op8("sub_ovf",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // start and operand changes while busy are ignored; soma holds 0x7F
        // from the previous operation until the new FIN.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        nb = 0; nd = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1;
            end
            if (n == 4) start = 1'b0;
            if (n == 5) chk("busy.hold", 32'(soma), 32'h7F);
            if (busy) nb++;
            if (done) nd++;
        end
        $display("busy test: busy cycles=%0d done pulses=%0d soma=%02h", nb, nd, soma);
        chk("busy.cycles", 32'(nb),       32'd9);
        chk("busy.dones",  32'(nd),       32'd1);
        chk("busy.soma",   32'(soma),     32'h10);
        chk("busy.cout",   32'(cout),     32'd0);
        chk("busy.ovf",    32'(overflow), 32'd0);

        // Reset in the middle of SHIFT, with start held high during reset.
        @(negedge clk);
        a = 8'hFF; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("mrst.busy", 32'(busy),     32'd0);
        chk("mrst.soma", 32'(soma),     32'd0);
        chk("mrst.cout", 32'(cout),     32'd0);
        chk("mrst.ovf",  32'(overflow), 32'd0);
        chk("mrst.done", 32'(done),     32'd0);
        @(negedge clk);
        chk("mrst.busy2", 32'(busy), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        nd = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) nd++;
        end
        $display("reset test: done pulses after reset=%0d soma=%02h", nd, soma);
        chk("mrst.nodone", 32'(nd),   32'd0);
        chk("mrst.soma2",  32'(soma), 32'd0);
        op8("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Randomized back-to-back sweep with start held high.
        @(negedge clk);
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        exp = model(8, 32'(a), 32'(b), sub, cin);
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done && gap < 40);
            chk("rnd.gap",  32'(gap),      (i == 0) ? 32'd9 : 32'd10);
            chk("rnd.soma", 32'(soma),     32'(exp[7:0]));
            chk("rnd.cout", 32'(cout),     32'(exp[32]));
            chk("rnd.ovf",  32'(overflow), 32'(exp[33]));
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            exp = model(8, 32'(a), 32'(b), sub, cin);
        end
        start = 1'b0;
        $display("random sweep: 1000 back-to-back operations checked");

        // WIDTH=1: every combination of a, b, cin and sub.
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            a1 = v[0]; b1 = v[1]; cin1 = v[2]; sub1 = v[3]; start1 = 1'b1;
            exp = model(1, 32'(a1), 32'(b1), sub1, cin1);
            @(negedge clk);
            start1 = 1'b0;
            lat = 1;
            while (!done1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            $display("w1: a=%0d b=%0d cin=%0d sub=%0d -> soma=%0d cout=%0d ovf=%0d lat=%0d",
                     a1, b1, cin1, sub1, soma1, cout1, overflow1, lat);
            chk("w1.lat",  32'(lat),       32'd2);
            chk("w1.soma", 32'(soma1),     32'(exp[0]));
            chk("w1.cout", 32'(cout1),     32'(exp[32]));
            chk("w1.ovf",  32'(overflow1), 32'(exp[33]));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/somador_serial.md
SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1 to 32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an operation.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 The block SHALL have port cin, input, 1 bit, the carry-in for add (ignored when sub=1); sampled with start.
REQ-007 The block SHALL have ports a and b, each input, WIDTH bits, the operands; sampled with start.
REQ-008 The block SHALL have port soma, output, WIDTH bits, the result register.
REQ-009 The block SHALL have port cout, output, 1 bit, the carry out of the MSB (for subtract, 1 = no borrow).
REQ-010 The block SHALL have port overflow, output, 1 bit, the two's-complement signed overflow.
REQ-011 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking valid results.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and FIN, using a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch a, b (b inverted when sub=1), sub and cin, and SHALL move the FSM to SHIFT.
  - bit counter = 0
  - carry register = sub ? 1 : cin
REQ-015 In SHIFT, each cycle SHALL process one bit, LSB first.
  - sum bit = a_i XOR b_i XOR carry
  - carry = majority(a_i, b_i, carry)
  - sum bit shifted into soma from the MSB side
  - bit counter increments by 1
REQ-016 After exactly WIDTH SHIFT cycles, the FSM SHALL move to FIN.
REQ-017 On the transition into FIN, the block SHALL set the outputs as follows.
  - soma = full WIDTH-bit result
  - cout = final carry
  - overflow = carry into the MSB XOR final carry
REQ-018 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge k gives done=1 during the cycle following edge k+WIDTH, independent of operand values.
REQ-020 busy SHALL be 1 in SHIFT and FIN, and 0 in IDLE.
REQ-021 start SHALL be ignored in SHIFT and FIN; changes to a, b, sub and cin during an operation SHALL NOT affect the result.
REQ-022 soma, cout and overflow SHALL hold their values from FIN until the next FIN; they SHALL NOT change during SHIFT of a later operation.
REQ-023 start held high continuously SHALL start a new operation on the first IDLE edge after each FIN, giving back-to-back operations of WIDTH+2 cycles each.
REQ-024 With WIDTH=1, the block SHALL behave as a registered full adder with a latency of 1 SHIFT cycle.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; there SHALL be no saturation.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL enter IDLE regardless of state, including mid-SHIFT.
  - soma = 0, cout = 0, overflow = 0, busy = 0, done = 0
  - counter and carry cleared
REQ-027 An operation interrupted by reset SHALL produce no done pulse, and its partial result SHALL NOT appear on soma.
REQ-028 While rst_n=0, start SHALL be ignored; the first operation SHALL be accepted at the first edge with rst_n=1 and start=1.

Verification (WIDTH=8 unless stated)
REQ-029 Add, no carry: a=0x0F, b=0x01, sub=0, cin=0 -> done 9 cycles after the start edge; soma=0x10, cout=0, overflow=0.
REQ-030 Add, wrap and signed overflow:
  - a=0xFF, b=0x01 -> soma=0x00, cout=1, overflow=0
  - a=0x7F, b=0x01 -> soma=0x80, cout=0, overflow=1
  - a=0xFF, b=0x00, cin=1 -> soma=0x00, cout=1
REQ-031 Subtract: a=0x05, b=0x07, sub=1 -> soma=0xFE, cout=0, overflow=0; a=0x80, b=0x01, sub=1 -> soma=0x7F, cout=1, overflow=1.
REQ-032 Busy rules: start pulsed, and a changed, on cycle 3 of SHIFT -> result unchanged, a single done pulse, busy=1 for exactly 9 cycles.
REQ-033 Reset mid-operation: rst_n=0 on cycle 4 of SHIFT -> next cycle busy=0, soma=0, no done pulse; a new start then completes normally.
REQ-034 Exhaustive check with WIDTH=1 (all 8 combinations of a, b, cin) and a randomized sweep with WIDTH=8 (at least 1000 operations, back-to-back start) -> every result equals a+b+cin or a-b modulo 2^WIDTH, with matching cout and overflow.
